// File: rtl/pcileech_com_rx_demux.sv
// pcileech_com_rx_demux
//   Classifies 64-bit host words from the communication core RX path and
//   routes them to a TLP DW stream (buffered, since upstream cannot stall),
//   a register-write strobe, or a command strobe.  TLP overflow and errors
//   are handled by dropping up to the next "last" DW, with sticky status
//   and saturating counters.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   din, din_valid      host word: [63:32] payload DW, [31:0] header
//   tlp_data/last/valid/ready  TLP DW stream out of the internal FIFO
//   reg_wr_addr/data/en register write (addr = header[31:16])
//   cmd_data/en         command payload and strobe
//   sts_overflow        sticky TLP FIFO overflow flag
//   sts_clear           clears sts_overflow and both counters
//   cnt_bad_magic       words rejected for a bad header
//   cnt_tlp_drop        TLP DWs discarded
module pcileech_com_rx_demux #(
  parameter int TLP_FIFO_DEPTH = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          din,
  input  logic                 din_valid,
  output logic [31:0]          tlp_data,
  output logic                 tlp_last,
  output logic                 tlp_valid,
  input  logic                 tlp_ready,
  output logic [15:0]          reg_wr_addr,
  output logic [31:0]          reg_wr_data,
  output logic                 reg_wr_en,
  output logic [31:0]          cmd_data,
  output logic                 cmd_en,
  output logic                 sts_overflow,
  input  logic                 sts_clear,
  output logic [CNT_WIDTH-1:0] cnt_bad_magic,
  output logic [CNT_WIDTH-1:0] cnt_tlp_drop
);

  localparam int AW = $clog2(TLP_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PKT     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Header decode
  logic [7:0]  magic;
  logic [1:0]  wtype;
  logic        hlast;
  logic [31:0] payload;
  logic        hdr_ok, word_idle, word_bad, word_tlp, word_reg, word_cmd;

  assign magic     = din[7:0];
  assign wtype     = din[9:8];
  assign hlast     = din[10];
  assign payload   = din[63:32];
  assign word_idle = (din == 64'h0);
  assign hdr_ok    = (magic == 8'h77) && (wtype != 2'b11);
  assign word_bad  = din_valid && !word_idle && !hdr_ok;
  assign word_tlp  = din_valid && hdr_ok && (wtype == 2'b00);
  assign word_reg  = din_valid && hdr_ok && (wtype == 2'b01);
  assign word_cmd  = din_valid && hdr_ok && (wtype == 2'b10);

  // TLP FIFO: pointers carry an extra MSB to tell full from empty
  logic [32:0] mem [TLP_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop, drop, ovf_set;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tlp_valid = !empty;
  assign pop       = tlp_valid && tlp_ready;
  assign tlp_data  = tlp_valid ? mem[rd_ptr[AW-1:0]][31:0] : '0;
  assign tlp_last  = tlp_valid ? mem[rd_ptr[AW-1:0]][32]   : 1'b0;

  // A same-cycle pop frees the head slot, so a push into a full FIFO is
  // still accepted; the old head is read combinationally before the write.
  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    ovf_set   = 1'b0;
    state_nxt = state;
    if (word_tlp) begin
      if (state == S_DISCARD) begin
        drop      = 1'b1;
        state_nxt = hlast ? S_IDLE : S_DISCARD;
      end else if (!full || pop) begin
        push      = 1'b1;
        state_nxt = hlast ? S_IDLE : S_PKT;
      end else begin
        drop      = 1'b1;
        ovf_set   = 1'b1;
        state_nxt = hlast ? S_IDLE : S_DISCARD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {hlast, payload};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= S_IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state <= state_nxt;
    end
  end

  // Status and saturating counters; sts_clear wins over a coincident event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sts_overflow  <= 1'b0;
      cnt_bad_magic <= '0;
      cnt_tlp_drop  <= '0;
    end else if (sts_clear) begin
      sts_overflow  <= 1'b0;
      cnt_bad_magic <= '0;
      cnt_tlp_drop  <= '0;
    end else begin
      if (ovf_set) sts_overflow <= 1'b1;
      if (word_bad && (cnt_bad_magic != '1))
        cnt_bad_magic <= cnt_bad_magic + CNT_WIDTH'(1);
      if (drop && (cnt_tlp_drop != '1))
        cnt_tlp_drop <= cnt_tlp_drop + CNT_WIDTH'(1);
    end
  end

  // Register and command strobes, independent of TLP state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      cmd_en      <= 1'b0;
      cmd_data    <= '0;
    end else begin
      reg_wr_en <= word_reg;
      cmd_en    <= word_cmd;
      if (word_reg) begin
        reg_wr_addr <= din[31:16];
        reg_wr_data <= payload;
      end
      if (word_cmd) begin
        cmd_data <= payload;
      end
    end
  end

endmodule

// File: tb/tb_pcileech_com_rx_demux.sv
// Self-checking bench for pcileech_com_rx_demux: directed scenarios followed
// by randomized traffic, compared against a queue-based reference model.
module tb_pcileech_com_rx_demux;

  localparam int DEPTH  = 16;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   din;
  logic          din_valid;
  logic [31:0]   tlp_data;
  logic          tlp_last;
  logic          tlp_valid;
  logic          tlp_ready;
  logic [15:0]   reg_wr_addr;
  logic [31:0]   reg_wr_data;
  logic          reg_wr_en;
  logic [31:0]   cmd_data;
  logic          cmd_en;
  logic          sts_overflow;
  logic          sts_clear;
  logic [CW-1:0] cnt_bad_magic;
  logic [CW-1:0] cnt_tlp_drop;

  pcileech_com_rx_demux #(
    .TLP_FIFO_DEPTH(DEPTH),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .tlp_data     (tlp_data),
    .tlp_last     (tlp_last),
    .tlp_valid    (tlp_valid),
    .tlp_ready    (tlp_ready),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_en    (reg_wr_en),
    .cmd_data     (cmd_data),
    .cmd_en       (cmd_en),
    .sts_overflow (sts_overflow),
    .sts_clear    (sts_clear),
    .cnt_bad_magic(cnt_bad_magic),
    .cnt_tlp_drop (cnt_tlp_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d;
    logic        l;
  } ent_t;

  ent_t        exp_q[$];
  int          occ;
  bit          m_discard;
  int          m_bad, m_drop;
  bit          m_ovf, m_reg_en, m_cmd_en;
  logic [15:0] m_addr;
  logic [31:0] m_rdata, m_cdata;
  bit          ev_bad, ev_drop, ev_ovf;
  logic [31:0] mh;
  ent_t        ment;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      occ = 0; m_discard = 0; m_bad = 0; m_drop = 0; m_ovf = 0;
      m_reg_en = 0; m_cmd_en = 0; m_addr = '0; m_rdata = '0; m_cdata = '0;
    end else begin
      m_reg_en = 0; m_cmd_en = 0;
      ev_bad = 0; ev_drop = 0; ev_ovf = 0;
      if (tlp_ready && occ > 0) occ--;
      if (din_valid && din != 64'h0) begin
        mh = din[31:0];
        if (mh[7:0] != 8'h77 || mh[9:8] == 2'b11) ev_bad = 1;
        else if (mh[9:8] == 2'b00) begin
          if (m_discard) begin
            ev_drop = 1;
            m_discard = !mh[10];
          end else if (occ < DEPTH) begin
            ment.d = din[63:32];
            ment.l = mh[10];
            exp_q.push_back(ment);
            occ++;
          end else begin
            ev_drop = 1; ev_ovf = 1;
            m_discard = !mh[10];
          end
        end else if (mh[9:8] == 2'b01) begin
          m_reg_en = 1; m_addr = mh[31:16]; m_rdata = din[63:32];
        end else begin
          m_cmd_en = 1; m_cdata = din[63:32];
        end
      end
      if (sts_clear) begin
        m_bad = 0; m_drop = 0; m_ovf = 0;
      end else begin
        if (ev_bad && m_bad < CNTMAX) m_bad++;
        if (ev_drop && m_drop < CNTMAX) m_drop++;
        if (ev_ovf) m_ovf = 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("tlp_valid", tlp_valid, occ > 0);
      if (tlp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tlp_unexpected actual=%0h expected=none t=%0t", tlp_data, $time);
        end else begin
          check("tlp_data", tlp_data, exp_q[0].d);
          check("tlp_last", tlp_last, exp_q[0].l);
          if (tlp_ready) void'(exp_q.pop_front());
        end
      end
      check("reg_wr_en", reg_wr_en, m_reg_en);
      check("reg_wr_addr", reg_wr_addr, m_addr);
      check("reg_wr_data", reg_wr_data, m_rdata);
      check("cmd_en", cmd_en, m_cmd_en);
      check("cmd_data", cmd_data, m_cdata);
      check("cnt_bad_magic", cnt_bad_magic, m_bad);
      check("cnt_tlp_drop", cnt_tlp_drop, m_drop);
      check("sts_overflow", sts_overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [63:0] tlp_w(input logic [31:0] p, input logic last);
    return {p, 16'h0, 5'h0, last, 2'b00, 8'h77};
  endfunction

  function automatic logic [63:0] reg_w(input logic [15:0] a, input logic [31:0] p);
    return {p, a, 6'h0, 2'b01, 8'h77};
  endfunction

  function automatic logic [63:0] cmd_w(input logic [31:0] p);
    return {p, 16'h0, 6'h0, 2'b10, 8'h77};
  endfunction

  task automatic send(input logic [63:0] w);
    din = w; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill_full();
    for (int i = 0; i < DEPTH; i++) send(tlp_w(32'hF000 + 32'(i), i == DEPTH - 1));
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1; din = '0; din_valid = 1'b0; tlp_ready = 1'b0; sts_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    check("rst_tlp_valid", tlp_valid, 0);
    check("rst_tlp_data", tlp_data, 0);
    check("rst_reg_addr", reg_wr_addr, 0);
    check("rst_cnt_drop", cnt_tlp_drop, 0);

    // 1: simple 3-DW packet
    tlp_ready = 1'b1;
    send(tlp_w(32'hA1, 0)); send(tlp_w(32'hA2, 0)); send(tlp_w(32'hA3, 1));
    idle(4);
    check("t1_cnt_drop", cnt_tlp_drop, 0);
    check("t1_cnt_bad", cnt_bad_magic, 0);

    // 2: overflow of a 20-DW packet with ready low
    tlp_ready = 1'b0;
    for (int i = 1; i <= 20; i++) send(tlp_w(32'h200 + 32'(i), i == 20));
    idle(1);
    check("t2_cnt_drop", cnt_tlp_drop, 4);
    check("t2_overflow", sts_overflow, 1);
    tlp_ready = 1'b1;
    idle(DEPTH + 3);
    check("t2_drained", tlp_valid, 0);
    sts_clear = 1'b1; idle(1); sts_clear = 1'b0;
    check("t2_clr_drop", cnt_tlp_drop, 0);
    check("t2_clr_ovf", sts_overflow, 0);

    // 3: REG and CMD words inside a TLP
    send(tlp_w(32'hB1, 0));
    send(reg_w(16'h0018, 32'h3));
    send(tlp_w(32'hB2, 0));
    send(cmd_w(32'hC0DE0001));
    send(tlp_w(32'hB3, 1));
    idle(3);
    check("t3_reg_addr", reg_wr_addr, 16'h0018);
    check("t3_reg_data", reg_wr_data, 32'h3);
    check("t3_cmd_data", cmd_data, 32'hC0DE0001);

    // 4: bad magic, reserved type, idle word
    send({32'h1234, 16'h0, 8'h00, 8'h76});
    send({32'h5, 16'h0, 6'h0, 2'b11, 8'h77});
    send(64'h0);
    idle(2);
    check("t4_cnt_bad", cnt_bad_magic, 2);
    check("t4_fifo", tlp_valid, 0);

    // 5: full FIFO with pop and push in the same cycle
    tlp_ready = 1'b0;
    fill_full();
    tlp_ready = 1'b1;
    send(tlp_w(32'hCCCC, 1));
    check("t5_cnt_drop", cnt_tlp_drop, 0);
    check("t5_overflow", sts_overflow, 0);
    idle(DEPTH + 3);

    // 6: asynchronous reset mid-packet, then a fresh packet
    tlp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(tlp_w(32'hE0 + 32'(i), 0));
    #3 rst = 1'b1;
    #1 check("t6_rst_valid", tlp_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    tlp_ready = 1'b1;
    send(tlp_w(32'hD1, 1));
    idle(3);
    check("t6_after_valid", tlp_valid, 0);

    // 6b: sts_clear coincident with an overflow drop
    tlp_ready = 1'b0;
    fill_full();
    sts_clear = 1'b1;
    send(tlp_w(32'hDEAD, 1));
    sts_clear = 1'b0;
    check("t6_clr_drop", cnt_tlp_drop, 0);
    check("t6_clr_ovf", sts_overflow, 0);
    tlp_ready = 1'b1;
    idle(DEPTH + 3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tlp_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      sts_clear = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 15);
      din_valid = 1'b1;
      case (r)
        0, 1, 2, 3, 4, 5: din = tlp_w($urandom, $urandom_range(0, 5) == 0);
        6:  din = reg_w(16'($urandom), $urandom);
        7:  din = cmd_w($urandom);
        8:  din = {$urandom, 16'h0, 8'h0, 8'($urandom_range(0, 118))};
        9:  din = {$urandom, 16'($urandom), 6'h0, 2'b11, 8'h77};
        10: din = 64'h0;
        11: din = {$urandom, $urandom};
        default: begin din_valid = 1'b0; din = '0; end
      endcase
      @(posedge clk); #1;
    end
    din_valid = 1'b0; din = '0; sts_clear = 1'b0; tlp_ready = 1'b1;
    idle(DEPTH + 5);
    check("final_scoreboard_empty", exp_q.size(), 0);
    check("final_valid", tlp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
